dm_sbus_arbiter: RTL and testbench
==================================

DM_SBUS_ARBITER -- requirements
Module: dm_sbus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: number of RESP-state cycles without bus_r_valid_i before the block issues an error response; legal range 1..65535.
REQ-002 clk_i  in  1  single clock; all logic rising-edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 dmactive_i  in  1  debug module active; low masks the SBA requester.
REQ-005 sba_req_i / core_req_i  in  1 each  requester bus request; held until the matching gnt.
REQ-006 sba_add_i / core_add_i  in  32 each  request address.
REQ-007 sba_we_i / core_we_i  in  1 each  write enable.
REQ-008 sba_wdata_i / core_wdata_i  in  32 each  write data.
REQ-009 sba_be_i / core_be_i  in  4 each  byte enables.
REQ-010 sba_gnt_o / core_gnt_o  out  1 each  per-requester grant.
REQ-011 sba_r_valid_o / core_r_valid_o  out  1 each  per-requester response valid.
REQ-012 sba_r_err_o, sba_r_other_err_o / core_r_err_o, core_r_other_err_o  out  1 each  per-requester response error flags.
REQ-013 sba_r_rdata_o / core_r_rdata_o  out  32 each  per-requester read data.
REQ-014 bus_req_o, bus_we_o  out  1 each  shared system bus request and write enable.
REQ-015 bus_add_o, bus_wdata_o  out  32 each  shared system bus address and write data.
REQ-016 bus_be_o  out  4  shared system bus byte enables.
REQ-017 bus_gnt_i, bus_r_valid_i, bus_r_err_i, bus_r_other_err_i  in  1 each  bus grant, response valid and response error flags.
REQ-018 bus_r_rdata_i  in  32  bus read data.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, RESP, DRAIN; at most one bus transaction is outstanding at any time.
REQ-020 In IDLE with any effective request, the arbiter SHALL latch the winner into owner and enter REQ on the next edge. Effective SBA request = sba_req_i & dmactive_i.
REQ-021 Round-robin: when both requesters request, the requester not equal to last_owner SHALL win; a single requester always wins.
REQ-022 In REQ, bus_req_o=1 and bus_add/we/wdata/be SHALL be a combinational mux of owner's inputs; in all other states bus_req_o=0 and the bus fields are 0.
REQ-023 In REQ, owner gnt_o = bus_gnt_i in the same cycle (combinational); the non-owner gnt_o SHALL stay 0; on bus_gnt_i the FSM SHALL enter RESP.
REQ-024 If owner drops its request in REQ without a grant, or dmactive_i falls while SBA owns in REQ, the FSM SHALL return to IDLE with no bus grant issued.
REQ-025 In RESP, owner r_valid/r_err/r_other_err/r_rdata SHALL equal the bus_r_* inputs in the same cycle. On bus_r_valid_i: last_owner<=owner, go to IDLE.
REQ-026 The non-owner response outputs and all response outputs outside RESP SHALL be 0, except the timeout pulse (REQ-027).
REQ-027 A 16-bit counter SHALL clear on RESP entry and increment each RESP cycle. When it reaches TIMEOUT with no bus_r_valid_i, the block SHALL drive owner r_valid_o=1 and r_other_err_o=1 with r_rdata_o=0 for one cycle, set last_owner, and enter DRAIN.
REQ-028 In DRAIN, no grants SHALL be issued. bus_r_valid_i SHALL be consumed silently and return the FSM to IDLE.
REQ-029 A bus_r_valid_i in IDLE or REQ SHALL be ignored.
REQ-030 Minimum transaction latency: request at cycle N, bus_req_o at N+1; with immediate gnt and r_valid at N+2, the FSM is back in IDLE at N+3.
REQ-031 A dmactive_i fall during RESP or DRAIN SHALL NOT abort the transaction; the response is still delivered (RESP) or drained (DRAIN).

Reset
REQ-032 On rst_ni low: state=IDLE, owner=SBA, last_owner=CORE (SBA wins the first tie), counter=0, all outputs 0. Reset mid-transaction SHALL abandon it with no response issued.

Structure
REQ-033 Package dm_sbus_pkg SHALL hold the owner enum (SBA, CORE), the state enum, the request and response structs, and the TIMEOUT default.
REQ-034 One sub-module, dm_sbus_watchdog (counter, clear, enable, expiry flag), SHALL be instantiated; everything else stays flat.

Verification
REQ-035 SBA single read of 0x1000, bus_gnt_i immediate, r_valid with 0xCAFEF00D next cycle -> sba_r_rdata_o=0xCAFEF00D, core outputs 0.
REQ-036 Both requesting from reset, held for 3 transactions -> grant order SBA, CORE, SBA.
REQ-037 TIMEOUT=4, no bus_r_valid_i -> owner gets one-cycle r_valid+r_other_err 4 cycles after grant. A late r_valid is dropped and the next grant occurs only after it.
REQ-038 dmactive_i=0 with sba_req_i=1 and core_req_i=1 -> only CORE granted. dmactive_i falling during SBA REQ -> return to IDLE, no sba_gnt_o.
REQ-039 Reset asserted in RESP -> all outputs 0 asynchronously; after release, the next request completes normally.

Source files
------------

// File: rtl/dm_sbus_pkg.sv
// Shared types for the debug-module system bus arbiter: owners, FSM states,
// request/response bundles and the default response timeout.
package dm_sbus_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic {
        OWNER_SBA  = 1'b0,
        OWNER_CORE = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sbus_req_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic        other_err;
        logic [31:0] rdata;
    } sbus_resp_t;

endpackage

// File: rtl/dm_sbus_watchdog.sv
// Response watchdog: counts RESP cycles and flags the cycle in which the
// TIMEOUT-th consecutive cycle without a bus response is reached.
module dm_sbus_watchdog
    import dm_sbus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    // count holds the completed RESP cycles, so the current one is count+1
    assign expired = enable && (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/dm_sbus_arbiter.sv
// Two-requester (SBA, core) round-robin arbiter onto a single system bus,
// with at most one outstanding transaction and a response timeout.
module dm_sbus_arbiter
    import dm_sbus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmactive_i,
    input  logic        sba_req_i,
    input  logic [31:0] sba_add_i,
    input  logic        sba_we_i,
    input  logic [31:0] sba_wdata_i,
    input  logic [3:0]  sba_be_i,
    output logic        sba_gnt_o,
    output logic        sba_r_valid_o,
    output logic        sba_r_err_o,
    output logic        sba_r_other_err_o,
    output logic [31:0] sba_r_rdata_o,
    input  logic        core_req_i,
    input  logic [31:0] core_add_i,
    input  logic        core_we_i,
    input  logic [31:0] core_wdata_i,
    input  logic [3:0]  core_be_i,
    output logic        core_gnt_o,
    output logic        core_r_valid_o,
    output logic        core_r_err_o,
    output logic        core_r_other_err_o,
    output logic [31:0] core_r_rdata_o,
    output logic        bus_req_o,
    output logic [31:0] bus_add_o,
    output logic        bus_we_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_r_valid_i,
    input  logic        bus_r_err_i,
    input  logic        bus_r_other_err_i,
    input  logic [31:0] bus_r_rdata_i
);

    state_e     state;
    state_e     state_next;
    owner_e     owner;
    owner_e     last_owner;
    owner_e     winner;
    sbus_req_t  sba_bus;
    sbus_req_t  core_bus;
    sbus_req_t  own_bus;
    sbus_resp_t resp;
    logic       any_req;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;

    // An inactive debug module hides the SBA request from arbitration entirely
    assign sba_bus  = '{req: sba_req_i & dmactive_i, add: sba_add_i, we: sba_we_i,
                        wdata: sba_wdata_i, be: sba_be_i};
    assign core_bus = '{req: core_req_i, add: core_add_i, we: core_we_i,
                        wdata: core_wdata_i, be: core_be_i};
    assign own_bus  = (owner == OWNER_SBA) ? sba_bus : core_bus;
    assign any_req  = sba_bus.req | core_bus.req;

    assign winner = (sba_bus.req && core_bus.req)
                  ? ((last_owner == OWNER_SBA) ? OWNER_CORE : OWNER_SBA)
                  : (sba_bus.req ? OWNER_SBA : OWNER_CORE);

    assign wd_clear  = (state == ST_REQ) && bus_gnt_i;
    assign wd_enable = (state == ST_RESP);

    dm_sbus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (any_req) state_next = ST_REQ;
            ST_REQ: begin
                if (bus_gnt_i) begin
                    state_next = ST_RESP;
                end else if (!own_bus.req) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (bus_r_valid_i) begin
                    state_next = ST_IDLE;
                end else if (wd_expired) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: if (bus_r_valid_i) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            owner      <= OWNER_SBA;
            last_owner <= OWNER_CORE;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && any_req) begin
                owner <= winner;
            end
            if (state == ST_RESP && (bus_r_valid_i || wd_expired)) begin
                last_owner <= owner;
            end
        end
    end

    always_comb begin
        bus_req_o   = 1'b0;
        bus_add_o   = '0;
        bus_we_o    = 1'b0;
        bus_wdata_o = '0;
        bus_be_o    = '0;
        sba_gnt_o   = 1'b0;
        core_gnt_o  = 1'b0;
        resp        = '0;
        if (state == ST_REQ) begin
            bus_req_o   = 1'b1;
            bus_add_o   = own_bus.add;
            bus_we_o    = own_bus.we;
            bus_wdata_o = own_bus.wdata;
            bus_be_o    = own_bus.be;
            sba_gnt_o   = (owner == OWNER_SBA) && bus_gnt_i;
            core_gnt_o  = (owner == OWNER_CORE) && bus_gnt_i;
        end
        // A real response always beats the timeout pulse in the same cycle
        if (state == ST_RESP) begin
            if (wd_expired && !bus_r_valid_i) begin
                resp = '{valid: 1'b1, err: 1'b0, other_err: 1'b1, rdata: '0};
            end else begin
                resp = '{valid: bus_r_valid_i, err: bus_r_err_i,
                         other_err: bus_r_other_err_i, rdata: bus_r_rdata_i};
            end
        end
    end

    assign sba_r_valid_o      = (owner == OWNER_SBA) && resp.valid;
    assign sba_r_err_o        = (owner == OWNER_SBA) && resp.err;
    assign sba_r_other_err_o  = (owner == OWNER_SBA) && resp.other_err;
    assign sba_r_rdata_o      = (owner == OWNER_SBA) ? resp.rdata : '0;
    assign core_r_valid_o     = (owner == OWNER_CORE) && resp.valid;
    assign core_r_err_o       = (owner == OWNER_CORE) && resp.err;
    assign core_r_other_err_o = (owner == OWNER_CORE) && resp.other_err;
    assign core_r_rdata_o     = (owner == OWNER_CORE) ? resp.rdata : '0;

endmodule

// File: tb/tb_dm_sbus_arbiter.sv
// Randomized scoreboard bench for dm_sbus_arbiter against a transaction-level
// model of the arbitration, timeout and drain rules.
module tb_dm_sbus_arbiter;
    import dm_sbus_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dmactive_i;
    logic        sba_req_i, sba_we_i, core_req_i, core_we_i;
    logic [31:0] sba_add_i, sba_wdata_i, core_add_i, core_wdata_i;
    logic [3:0]  sba_be_i, core_be_i;
    logic        sba_gnt_o, sba_r_valid_o, sba_r_err_o, sba_r_other_err_o;
    logic        core_gnt_o, core_r_valid_o, core_r_err_o, core_r_other_err_o;
    logic [31:0] sba_r_rdata_o, core_r_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_add_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_r_valid_i, bus_r_err_i, bus_r_other_err_i;
    logic [31:0] bus_r_rdata_i;

    always #5 clk_i = ~clk_i;

    dm_sbus_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .dmactive_i (dmactive_i),
        .sba_req_i (sba_req_i), .sba_add_i (sba_add_i), .sba_we_i (sba_we_i),
        .sba_wdata_i (sba_wdata_i), .sba_be_i (sba_be_i), .sba_gnt_o (sba_gnt_o),
        .sba_r_valid_o (sba_r_valid_o), .sba_r_err_o (sba_r_err_o),
        .sba_r_other_err_o (sba_r_other_err_o), .sba_r_rdata_o (sba_r_rdata_o),
        .core_req_i (core_req_i), .core_add_i (core_add_i), .core_we_i (core_we_i),
        .core_wdata_i (core_wdata_i), .core_be_i (core_be_i), .core_gnt_o (core_gnt_o),
        .core_r_valid_o (core_r_valid_o), .core_r_err_o (core_r_err_o),
        .core_r_other_err_o (core_r_other_err_o), .core_r_rdata_o (core_r_rdata_o),
        .bus_req_o (bus_req_o), .bus_add_o (bus_add_o), .bus_we_o (bus_we_o),
        .bus_wdata_o (bus_wdata_o), .bus_be_o (bus_be_o), .bus_gnt_i (bus_gnt_i),
        .bus_r_valid_i (bus_r_valid_i), .bus_r_err_i (bus_r_err_i),
        .bus_r_other_err_i (bus_r_other_err_i), .bus_r_rdata_i (bus_r_rdata_i)
    );

    typedef struct packed {
        logic        sba_gnt, sba_rv, sba_err, sba_oerr;
        logic [31:0] sba_rdata;
        logic        core_gnt, core_rv, core_err, core_oerr;
        logic [31:0] core_rdata;
        logic        bus_req, bus_we;
        logic [31:0] bus_add, bus_wdata;
        logic [3:0]  bus_be;
    } snap_t;

    typedef struct packed {
        logic [31:0] add;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    snap_t exp_q[$];
    int    grant_log[$];
    int    checks = 0;
    int    fails = 0;

    // Requester side: index 0 is SBA, 1 is core
    logic  pend [2];
    txn_t  txn [2];
    logic  prev_dm;

    // Transaction-level model: 0 waiting for a winner, 1 offered to the bus,
    // 2 awaiting the response, 3 discarding a late response
    int    phase = 0;
    int    own = 0;
    int    last = 1;
    int    waited = 0;

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic snap_t sample();
        snap_t s;
        s = '{sba_gnt: sba_gnt_o, sba_rv: sba_r_valid_o, sba_err: sba_r_err_o,
              sba_oerr: sba_r_other_err_o, sba_rdata: sba_r_rdata_o,
              core_gnt: core_gnt_o, core_rv: core_r_valid_o, core_err: core_r_err_o,
              core_oerr: core_r_other_err_o, core_rdata: core_r_rdata_o,
              bus_req: bus_req_o, bus_we: bus_we_o, bus_add: bus_add_o,
              bus_wdata: bus_wdata_o, bus_be: bus_be_o};
        return s;
    endfunction

    task automatic newTxn(input int r);
        pend[r] = 1'b1;
        txn[r]  = '{add: $urandom, we: 1'($urandom), wdata: $urandom, be: 4'($urandom)};
    endtask

    task automatic driveRequesters();
        sba_req_i   = pend[0];
        sba_add_i   = txn[0].add;
        sba_we_i    = txn[0].we;
        sba_wdata_i = txn[0].wdata;
        sba_be_i    = txn[0].be;
        core_req_i   = pend[1];
        core_add_i   = txn[1].add;
        core_we_i    = txn[1].we;
        core_wdata_i = txn[1].wdata;
        core_be_i    = txn[1].be;
    endtask

    task automatic setResp(inout snap_t e, input int who, input logic err,
                           input logic oerr, input logic [31:0] data);
        if (who == 0) begin
            e.sba_rv = 1'b1; e.sba_err = err; e.sba_oerr = oerr; e.sba_rdata = data;
        end else begin
            e.core_rv = 1'b1; e.core_err = err; e.core_oerr = oerr; e.core_rdata = data;
        end
    endtask

    // Predicts what this cycle's inputs produce and pushes any visible event
    task automatic modelStep();
        snap_t e;
        logic  sreq, creq, oreq;
        sreq = pend[0] && dmactive_i;
        creq = pend[1];
        e = '0;
        case (phase)
            0: if (sreq || creq) begin
                own   = (sreq && creq) ? 1 - last : (sreq ? 0 : 1);
                phase = 1;
            end
            1: begin
                oreq = (own == 0) ? sreq : creq;
                if (bus_gnt_i) begin
                    e.bus_req = 1'b1;
                    e.bus_add = txn[own].add;
                    e.bus_we = txn[own].we;
                    e.bus_wdata = txn[own].wdata;
                    e.bus_be = txn[own].be;
                    if (own == 0) e.sba_gnt = 1'b1;
                    else e.core_gnt = 1'b1;
                    exp_q.push_back(e);
                    pend[own] = 1'b0;
                    phase = 2;
                    waited = 0;
                end else if (!oreq) begin
                    phase = 0;
                end
            end
            2: begin
                if (bus_r_valid_i) begin
                    setResp(e, own, bus_r_err_i, bus_r_other_err_i, bus_r_rdata_i);
                    exp_q.push_back(e);
                    last = own;
                    phase = 0;
                end else if (waited + 1 == int'(TO)) begin
                    setResp(e, own, 1'b0, 1'b1, 32'h0);
                    exp_q.push_back(e);
                    last = own;
                    phase = 3;
                end else begin
                    waited++;
                end
            end
            default: if (bus_r_valid_i) phase = 0;
        endcase
    endtask

    // One clock of random requester and bus-slave behaviour (percentages)
    task automatic applyStimulus(input int p_new, input int p_gnt, input int p_rv,
                                 input int p_dm_low, input int p_drop);
        logic dropped;
        @(posedge clk_i);
        #1;
        dmactive_i = !chance(p_dm_low);
        dropped = 1'b0;
        for (int r = 0; r < 2; r++) begin
            if (pend[r] && chance(p_drop)) begin
                pend[r] = 1'b0;
                dropped = 1'b1;
            end else if (!pend[r] && chance(p_new)) begin
                newTxn(r);
            end
        end
        bus_gnt_i = (dropped || (prev_dm && !dmactive_i)) ? 1'b0 : chance(p_gnt);
        prev_dm = dmactive_i;
        bus_r_valid_i     = chance(p_rv);
        bus_r_err_i       = 1'($urandom);
        bus_r_other_err_i = 1'($urandom);
        bus_r_rdata_i     = $urandom;
        driveRequesters();
        modelStep();
    endtask

    task automatic checkOutput();
        snap_t a;
        snap_t e;
        a = sample();
        if (a.sba_gnt || a.core_gnt || a.sba_rv || a.core_rv) begin
            checks++;
            if (a.sba_gnt) grant_log.push_back(0);
            if (a.core_gnt) grant_log.push_back(1);
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_event at %0t: got %h, expected no event", $time, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("[TB] FAIL event at %0t: got %h, expected %h", $time, a, e);
                end
            end
        end
    endtask

    task automatic checkZero(input string name);
        snap_t a;
        a = sample();
        checks++;
        if (a !== '0) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected all zero", name, a);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) checkOutput();
    end

    initial begin
        int expect_order [3];
        expect_order = '{0, 1, 0};
        newTxn(0);
        newTxn(1);
        driveRequesters();
        dmactive_i = 1'b1;
        prev_dm = 1'b1;
        bus_gnt_i = 1'b1;
        bus_r_valid_i = 1'b1;
        bus_r_err_i = 1'b1;
        bus_r_other_err_i = 1'b1;
        bus_r_rdata_i = 32'h1234_5678;
        repeat (2) @(negedge clk_i);
        #1;
        checkZero("reset_state");
        rst_ni = 1'b1;
        modelStep();

        // Both held from reset with an instant bus: strict alternation
        repeat (12) applyStimulus(100, 100, 100, 0, 0);
        checks++;
        if (grant_log.size() < 3) begin
            fails++;
            $display("[TB] FAIL grant_count: got %0d, expected at least 3", grant_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grant_log[i] != expect_order[i]) begin
                    fails++;
                    $display("[TB] FAIL grant_order[%0d]: got %0d, expected %0d",
                             i, grant_log[i], expect_order[i]);
                end
            end
        end

        repeat (800) applyStimulus(40, 50, 30, 0, 0);
        repeat (40)  applyStimulus(60, 100, 0, 0, 0);
        repeat (600) applyStimulus(50, 40, 25, 0, 5);
        repeat (40)  applyStimulus(100, 60, 40, 100, 0);
        repeat (800) applyStimulus(50, 40, 30, 10, 5);

        // Asynchronous reset while a response is outstanding
        for (int i = 0; i < 300 && phase != 2; i++) applyStimulus(50, 100, 0, 0, 0);
        checks++;
        if (phase != 2) begin
            fails++;
            $display("[TB] FAIL reach_resp: got phase %0d, expected 2", phase);
        end
        bus_r_valid_i = 1'b0;
        bus_r_err_i = 1'b1;
        bus_r_other_err_i = 1'b1;
        bus_r_rdata_i = 32'hA5A5_5A5A;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        checkZero("async_reset");
        phase = 0;
        own = 0;
        last = 1;
        waited = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        modelStep();

        repeat (400) applyStimulus(50, 50, 30, 5, 3);
        repeat (20)  applyStimulus(0, 100, 100, 0, 0);
        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_events: got %0d left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
